// File: rtl/multi_digit_lock.sv
// Parametrised keypad combination lock with failed-attempt lockout and
// in-place reprogramming of the combination while open.
module multi_digit_lock #(
  parameter int DIGIT_WIDTH    = 4,
  parameter int NUM_DIGITS     = 4,
  parameter int MAX_FAILS      = 3,
  parameter int LOCKOUT_CYCLES = 16,
  parameter logic [NUM_DIGITS*DIGIT_WIDTH-1:0] DEFAULT_CODE = 16'h3232,
  localparam int IDX_W = (NUM_DIGITS > 2) ? $clog2(NUM_DIGITS) : 1,
  localparam int FC_W  = $clog2(MAX_FAILS + 1),
  localparam int TMR_W = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enter,
  input  logic [DIGIT_WIDTH-1:0] digit,
  input  logic                   program_en,
  output logic [2:0]             state,
  output logic                   open,
  output logic                   fail,
  output logic                   lockout,
  output logic [IDX_W-1:0]       digit_index,
  output logic [FC_W-1:0]        fail_count
);

  localparam logic [2:0] ST_ENTRY   = 3'd0;
  localparam logic [2:0] ST_OPEN    = 3'd1;
  localparam logic [2:0] ST_FAIL    = 3'd2;
  localparam logic [2:0] ST_LOCKOUT = 3'd3;
  localparam logic [2:0] ST_PROG    = 3'd4;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  logic [2:0]             state_q;
  logic [IDX_W-1:0]       idx_q;
  logic                   mismatch_q;
  logic [FC_W-1:0]        fc_q;
  logic [TMR_W-1:0]       timer_q;
  logic [DIGIT_WIDTH-1:0] code_q [NUM_DIGITS];
  logic                   digit_miss;

  assign digit_miss = (digit != code_q[idx_q]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_ENTRY;
      idx_q      <= '0;
      mismatch_q <= 1'b0;
      fc_q       <= '0;
      timer_q    <= '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        code_q[i] <= DEFAULT_CODE[i*DIGIT_WIDTH +: DIGIT_WIDTH];
      end
    end else begin
      case (state_q)
        ST_ENTRY: begin
          // Every digit is accepted; the verdict comes only after the last one.
          if (enter) begin
            if (idx_q == LAST_IDX) begin
              idx_q      <= '0;
              mismatch_q <= 1'b0;
              if (!(mismatch_q || digit_miss)) begin
                state_q <= ST_OPEN;
                fc_q    <= '0;
              end else if (int'(fc_q) + 1 < MAX_FAILS) begin
                fc_q    <= fc_q + FC_W'(1);
                state_q <= ST_FAIL;
              end else begin
                fc_q    <= FC_W'(MAX_FAILS);
                timer_q <= TMR_W'(LOCKOUT_CYCLES - 1);
                state_q <= ST_LOCKOUT;
              end
            end else begin
              idx_q      <= idx_q + IDX_W'(1);
              mismatch_q <= mismatch_q | digit_miss;
            end
          end
        end
        ST_FAIL: begin
          if (enter) state_q <= ST_ENTRY;
        end
        ST_OPEN: begin
          if (enter) begin
            state_q <= program_en ? ST_PROG : ST_ENTRY;
            idx_q   <= '0;
          end
        end
        ST_PROG: begin
          if (enter) begin
            code_q[idx_q] <= digit;
            if (idx_q == LAST_IDX) begin
              idx_q   <= '0;
              state_q <= ST_ENTRY;
            end else begin
              idx_q <= idx_q + IDX_W'(1);
            end
          end
        end
        ST_LOCKOUT: begin
          // Timer was loaded with LOCKOUT_CYCLES-1, so the exit edge is the last lockout cycle.
          if (timer_q == '0) begin
            state_q <= ST_ENTRY;
            fc_q    <= '0;
          end else begin
            timer_q <= timer_q - TMR_W'(1);
          end
        end
        default: begin
          state_q    <= ST_ENTRY;
          idx_q      <= '0;
          mismatch_q <= 1'b0;
        end
      endcase
    end
  end

  assign state       = state_q;
  assign open        = (state_q == ST_OPEN);
  assign fail        = (state_q == ST_FAIL);
  assign lockout     = (state_q == ST_LOCKOUT);
  assign digit_index = idx_q;
  assign fail_count  = fc_q;

endmodule

// File: tb/tb_multi_digit_lock.sv
// Bench for multi_digit_lock: directed scenarios plus random traffic on the
// default build against a sequence-level model, and directed checks on a 2x8 build.
module tb_multi_digit_lock;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  // Default build: 4 digits x 4 bits, code 2,3,2,3
  logic       en = 1'b0, pg = 1'b0;
  logic [3:0] dg = '0;
  logic [2:0] st;
  logic       op, fl, lk;
  logic [1:0] di;
  logic [1:0] fc;

  // Second build: 2 digits x 8 bits, code 5A,A5
  logic       en2 = 1'b0, pg2 = 1'b0;
  logic [7:0] dg2 = '0;
  logic [2:0] st2;
  logic       op2, fl2, lk2;
  logic [0:0] di2;
  logic [1:0] fc2;

  int checks = 0;
  int errors = 0;

  // Sequence-level reference model of the default build
  int m_state;
  int m_code[4];
  int m_q[$];
  int m_fc;
  int m_left;
  int m_pidx;

  always #5 clk = ~clk;

  multi_digit_lock dut (
    .clk(clk), .rst_n(rst_n), .enter(en), .digit(dg), .program_en(pg),
    .state(st), .open(op), .fail(fl), .lockout(lk),
    .digit_index(di), .fail_count(fc)
  );

  multi_digit_lock #(
    .DIGIT_WIDTH(8), .NUM_DIGITS(2), .MAX_FAILS(3), .LOCKOUT_CYCLES(16),
    .DEFAULT_CODE(16'hA55A)
  ) dut2 (
    .clk(clk), .rst_n(rst_n), .enter(en2), .digit(dg2), .program_en(pg2),
    .state(st2), .open(op2), .fail(fl2), .lockout(lk2),
    .digit_index(di2), .fail_count(fc2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0;
    m_code  = '{2, 3, 2, 3};
    m_q.delete();
    m_fc    = 0;
    m_left  = 0;
    m_pidx  = 0;
  endtask

  task automatic model_step(input bit e, input int d, input bit p);
    bit ok;
    case (m_state)
      0: if (e) begin
        m_q.push_back(d);
        if (m_q.size() == 4) begin
          ok = 1'b1;
          for (int i = 0; i < 4; i++) if (m_q[i] != m_code[i]) ok = 1'b0;
          m_q.delete();
          if (ok) begin
            m_state = 1;
            m_fc = 0;
          end else begin
            m_fc++;
            if (m_fc >= 3) begin
              m_state = 3;
              m_left = 16;
            end else m_state = 2;
          end
        end
      end
      1: if (e) begin
        if (p) begin
          m_state = 4;
          m_pidx = 0;
        end else m_state = 0;
      end
      2: if (e) m_state = 0;
      3: begin
        m_left--;
        if (m_left == 0) begin
          m_state = 0;
          m_fc = 0;
        end
      end
      4: if (e) begin
        m_code[m_pidx] = d;
        m_pidx++;
        if (m_pidx == 4) begin
          m_pidx = 0;
          m_state = 0;
        end
      end
      default: m_state = 0;
    endcase
  endtask

  function automatic int model_idx();
    if (m_state == 0) return m_q.size();
    if (m_state == 4) return m_pidx;
    return 0;
  endfunction

  task automatic check_model();
    check("state", 32'(st), 32'(m_state));
    check("open", 32'(op), 32'(m_state == 1));
    check("fail", 32'(fl), 32'(m_state == 2));
    check("lockout", 32'(lk), 32'(m_state == 3));
    check("digit_index", 32'(di), 32'(model_idx()));
    check("fail_count", 32'(fc), 32'(m_fc));
  endtask

  // One clock: model samples the same inputs the DUT sees at the edge.
  task automatic tick();
    @(posedge clk);
    model_step(en, int'(dg), pg);
    #1;
    check_model();
  endtask

  task automatic key(input int d, input bit p = 1'b0);
    en = 1'b1;
    dg = 4'(d);
    pg = p;
    tick();
    en = 1'b0;
    pg = 1'b0;
  endtask

  task automatic key_seq(input int a, input int b, input int c, input int d);
    key(a); key(b); key(c); key(d);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Assert reset between edges and check that state drops without a clock.
  task automatic mid_reset(input string tag);
    en = 1'b0;
    pg = 1'b0;
    en2 = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check({tag, "_state"}, 32'(st), 32'd0);
    check({tag, "_idx"}, 32'(di), 32'd0);
    check({tag, "_open"}, 32'(op), 32'd0);
    model_reset();
    @(negedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic key2(input logic [7:0] d);
    en2 = 1'b1;
    dg2 = d;
    tick();
    en2 = 1'b0;
  endtask

  initial begin
    int lock_cycles;
    int choice;
    model_reset();
    #12;
    check("rst_state", 32'(st), 32'd0);
    check("rst_outs", 32'({op, fl, lk}), 32'd0);
    check("rst_idx_fc", 32'({di, fc}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Correct code opens, next Enter relocks
    key_seq(2, 3, 2, 3);
    check("open_2323", 32'(op), 32'd1);
    key(9);
    check("relock", 32'(st), 32'd0);

    // Wrong second digit: verdict only after the fourth digit
    key(2); key(9);
    check("no_early_fail", 32'(fl), 32'd0);
    key(2); key(3);
    check("fail_after_4", 32'(fl), 32'd1);
    check("fc_1", 32'(fc), 32'd1);
    key(5);
    key_seq(2, 3, 2, 3);
    check("open_after_fail", 32'(op), 32'd1);
    key(0);

    // Three wrong sequences -> lockout, Enter ignored while locked
    key_seq(1, 1, 1, 1); key(0);
    key_seq(1, 1, 1, 1); key(0);
    key_seq(1, 1, 1, 1);
    lock_cycles = 0;
    for (int i = 0; i < 40 && lk; i++) begin
      lock_cycles++;
      key((i % 2) ? 3 : 2);
    end
    check("lockout_len", 32'(lock_cycles), 32'd16);
    check("post_lock_fc", 32'(fc), 32'd0);
    key_seq(2, 3, 2, 3);
    check("open_after_lock", 32'(op), 32'd1);

    // Reprogram to 7,1,5,F
    key(0, 1'b1);
    check("prog_state", 32'(st), 32'd4);
    check("prog_open_low", 32'(op), 32'd0);
    key_seq(7, 1, 5, 15);
    key_seq(2, 3, 2, 3);
    check("old_code_fails", 32'(fl), 32'd1);
    key(0);
    key_seq(7, 1, 5, 15);
    check("new_code_opens", 32'(op), 32'd1);
    key(0);

    // Reset mid-sequence and mid-programming restores the default code
    key(7); key(1);
    mid_reset("rst_seq");
    key_seq(2, 3, 2, 3);
    check("open_after_rst", 32'(op), 32'd1);
    key(0, 1'b1); key(9); key(9);
    mid_reset("rst_prog");
    key_seq(2, 3, 2, 3);
    check("open_after_prog_rst", 32'(op), 32'd1);
    key(0);

    // Random traffic against the model
    for (int n = 0; n < 150; n++) begin
      choice = $urandom_range(0, 9);
      if (choice <= 2) begin
        for (int k = 0; k < 4; k++) key(m_code[k]);
      end else if (choice <= 5) begin
        for (int k = 0; k < 4; k++) begin
          if ($urandom_range(0, 2) == 0) tick();
          key($urandom_range(0, 15), 1'($urandom_range(0, 1)));
        end
      end else if (choice <= 7) begin
        key($urandom_range(0, 15), 1'b1);
        for (int k = 0; k < 4; k++) key($urandom_range(0, 15));
      end else if (choice == 8) begin
        idle($urandom_range(1, 20));
      end else begin
        key($urandom_range(0, 15));
        mid_reset("rand_rst");
      end
    end

    // Second build: 2 digits of 8 bits, code 5A,A5
    mid_reset("rst2");
    check("b2_rst_state", 32'(st2), 32'd0);
    key2(8'h5A);
    check("b2_idx_1", 32'(di2), 32'd1);
    check("b2_still_entry", 32'(st2), 32'd0);
    key2(8'hA5);
    check("b2_open", 32'(op2), 32'd1);
    check("b2_fc0", 32'(fc2), 32'd0);
    check("b2_idx_0", 32'(di2), 32'd0);
    key2(8'h00);
    check("b2_relock", 32'(st2), 32'd0);
    key2(8'h5A);
    key2(8'h00);
    check("b2_fail", 32'(fl2), 32'd1);
    check("b2_fc1", 32'(fc2), 32'd1);
    key2(8'h11);
    check("b2_fail_exit", 32'(st2), 32'd0);
    key2(8'h5A);
    key2(8'hA5);
    check("b2_open_again", 32'(op2), 32'd1);
    check("b2_fc_clear", 32'(fc2), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout reached before end of test");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/multi_digit_lock.md
# multi_digit_lock

Parametrised combination lock: accepts NUM_DIGITS keypad digits of DIGIT_WIDTH bits, one per Enter strobe, and opens only on a full correct sequence. It also has a failed-attempt counter with a timed lockout, and lets the user reprogram the combination while the lock is open. It sits between the debounced/synchronised keypad front end and the door actuator and status displays. It is the parametrised successor to the two-digit fixed-combination lock.

## Interface
- DIGIT_WIDTH, 4: bits per digit.
- NUM_DIGITS, 4: digits per combination; must be ≥2.
- MAX_FAILS, 3: consecutive wrong combinations that trigger lockout; must be ≥1.
- LOCKOUT_CYCLES, 16: clock cycles spent in LOCKOUT; must be ≥1.
- DEFAULT_CODE, 16'h3232: combination loaded at reset, NUM_DIGITS*DIGIT_WIDTH bits. Digit 0 is in the LSBs, so the default sequence is 2,3,2,3.
- Clock, input, 1: the single clock; all state updates on its rising edge.
- Reset, input, 1: asynchronous, active-low reset.
- Enter, input, 1: digit strobe. Each cycle it is high counts as one entry.
- Digit, input, DIGIT_WIDTH: digit value, sampled in cycles where Enter=1.
- Program, input, 1: qualifies Enter while in OPEN to start reprogramming.
- State, output, 3: current state encoding.
- Open, output, 1: high in OPEN.
- Fail, output, 1: high in FAIL.
- Lockout, output, 1: high in LOCKOUT.
- DigitIndex, output, max(1,clog2(NUM_DIGITS)): position of the next digit to be entered or programmed.
- FailCount, output, clog2(MAX_FAILS+1): current count of consecutive wrong combinations.

## Operation
- State encoding: ENTRY=3'd0, OPEN=3'd1, FAIL=3'd2, LOCKOUT=3'd3, PROG=3'd4. Values 5–7 are illegal and recover to ENTRY on the next edge.
- Registers:
  - Combination store (NUM_DIGITS*DIGIT_WIDTH bits).
  - DigitIndex.
  - Sticky mismatch flag.
  - FailCount.
  - Lockout timer.
- Reset (asynchronous, while Reset=0):
  - State=ENTRY, DigitIndex=0, mismatch=0, FailCount=0, timer=0.
  - Combination store = DEFAULT_CODE.
  - Open=Fail=Lockout=0.
- ENTRY, on Enter:
  - Compare Digit with the stored digit at DigitIndex; OR any mismatch into the sticky flag.
  - If DigitIndex<NUM_DIGITS-1: increment DigitIndex.
  - On the last digit, evaluate mismatch|this digit's mismatch, then clear DigitIndex and the mismatch flag:
    - Correct: go to OPEN and clear FailCount.
    - Wrong and FailCount+1<MAX_FAILS: increment FailCount and go to FAIL.
    - Wrong and FailCount+1==MAX_FAILS: set FailCount=MAX_FAILS, load timer with LOCKOUT_CYCLES-1, go to LOCKOUT.
  - Every digit is accepted until the end of the sequence, so the lock never reveals which position was wrong.
- FAIL: Enter returns to ENTRY. The digit on that Enter is discarded and is not counted as a first digit.
- OPEN:
  - Enter with Program=0: relock to ENTRY; the digit is discarded.
  - Enter with Program=1: go to PROG with DigitIndex=0.
- PROG:
  - Each Enter writes Digit into the store at DigitIndex and increments DigitIndex.
  - The write at index NUM_DIGITS-1 returns to ENTRY with DigitIndex=0. The new code takes effect for the next sequence.
  - Open stays 0 in PROG.
- LOCKOUT:
  - Enter is ignored.
  - The timer decrements each cycle.
  - In the cycle the timer reads 0, go to ENTRY and clear FailCount.
- Program is ignored in every state except OPEN.

## Timing
- All outputs are registered (Moore) and reflect state after the edge that samples Enter: one cycle of latency from the Enter cycle to Open/Fail/Lockout.
- DigitIndex updates on the same edge that samples Enter.
- Back-to-back Enter cycles are each a separate digit. There is no minimum gap.
- LOCKOUT lasts exactly LOCKOUT_CYCLES cycles: Lockout=1 for LOCKOUT_CYCLES cycles, then State=ENTRY.
- Reset mid-sequence or mid-PROG:
  - Abandons the partial entry.
  - Restores DEFAULT_CODE. A programmed code is not retained across reset.
  - Outputs drop asynchronously, without waiting for a clock edge.
- The reset release edge must not count an Enter: the first edge after Reset rises samples normally.

## Test plan
- Reset, then Enter 2,3,2,3 on consecutive cycles → Open=1 the cycle after the 4th Enter, FailCount=0, DigitIndex=0; next Enter (any digit) → ENTRY, Open=0.
- Enter 2,9,2,3 → Fail=1 only after the 4th digit, not after the 2nd, FailCount=1; Enter → ENTRY; then 2,3,2,3 → Open=1, FailCount=0.
- Three wrong sequences (MAX_FAILS=3) → Lockout=1 for exactly 16 cycles and Enter strobes during lockout are ignored; after that State=0, FailCount=0, and 2,3,2,3 opens.
- Open, then Enter with Program=1, then program 7,1,5,F → ENTRY; 2,3,2,3 → Fail; Enter; 7,1,5,F → Open.
- Assert Reset low after 2 digits or mid-PROG → State=0, DigitIndex=0 immediately; 2,3,2,3 opens (default code restored).
- Re-run the first two scenarios with NUM_DIGITS=2, DIGIT_WIDTH=8, DEFAULT_CODE=16'hA55A: sequence 5A,A5 → Open; 5A,00 → Fail.
